// File: rtl/ms_shift_pipe.sv
// Master-slave shift pipeline: DEPTH stages of WIDTH-bit master/slave pairs, bidirectional,
// with flush, per-stage valid tags and a fill count of valid slave stages.
module ms_shift_pipe #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     dir,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         d,
    input  logic                     d_valid,
    output logic [WIDTH-1:0]         q_out,
    output logic                     q_valid,
    output logic [WIDTH*DEPTH-1:0]   q_par,
    output logic [WIDTH-1:0]         master_tap,
    output logic [CW-1:0]            fill,
    output logic                     full,
    output logic                     empty
);

    logic [WIDTH-1:0] m_q [DEPTH];
    logic [WIDTH-1:0] m_d [DEPTH];
    logic [DEPTH-1:0] mv_q, mv_d;
    logic [WIDTH-1:0] s_q [DEPTH];
    logic [WIDTH-1:0] s_d [DEPTH];
    logic [DEPTH-1:0] sv_q, sv_d;
    logic [WIDTH-1:0] q_out_q, q_out_d;
    logic             q_valid_q, q_valid_d;
    logic [CW-1:0]    fill_q, fill_d;
    logic [WIDTH-1:0] m_exit;
    logic             mv_exit;

    // Masters load only from slaves, so every word advances exactly one stage per cycle.
    always_comb begin
        m_d  = m_q;
        mv_d = mv_q;
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_d[i] = '0;
            end
            mv_d = '0;
        end else if (en) begin
            if (!dir) begin
                m_d[0]  = d;
                mv_d[0] = d_valid;
                for (int i = 1; i < DEPTH; i++) begin
                    m_d[i]  = s_q[i-1];
                    mv_d[i] = sv_q[i-1];
                end
            end else begin
                m_d[DEPTH-1]  = d;
                mv_d[DEPTH-1] = d_valid;
                for (int i = 0; i < DEPTH - 1; i++) begin
                    m_d[i]  = s_q[i+1];
                    mv_d[i] = sv_q[i+1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        m_q  <= m_d;
        mv_q <= mv_d;
    end

    assign m_exit  = dir ? m_q[0]  : m_q[DEPTH-1];
    assign mv_exit = dir ? mv_q[0] : mv_q[DEPTH-1];

    always_comb begin
        s_d       = m_q;
        sv_d      = mv_q;
        q_out_d   = m_exit;
        q_valid_d = mv_exit;
        fill_d    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fill_d = fill_d + CW'(mv_q[i]);
        end
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                s_d[i] = '0;
            end
            sv_d      = '0;
            q_out_d   = '0;
            q_valid_d = 1'b0;
            fill_d    = '0;
        end
    end

    // Slave side and registered outputs update on the falling edge.
    always_ff @(negedge clk) begin
        s_q       <= s_d;
        sv_q      <= sv_d;
        q_out_q   <= q_out_d;
        q_valid_q <= q_valid_d;
        fill_q    <= fill_d;
    end

    always_comb begin
        q_par = '0;
        for (int i = 0; i < DEPTH; i++) begin
            q_par[i*WIDTH +: WIDTH] = s_q[i];
        end
    end

    assign q_out      = q_out_q;
    assign q_valid    = q_valid_q;
    assign master_tap = m_exit;
    assign fill       = fill_q;
    assign full       = (fill_q == CW'(DEPTH));
    assign empty      = (fill_q == '0);

endmodule

// File: tb/tb_ms_shift_pipe.sv
// Self-checking bench for ms_shift_pipe (WIDTH=8, DEPTH=4): vector table, directed corner
// sequences and randomized traffic against a stage-array reference model.
module tb_ms_shift_pipe;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = 3;

    logic           clk = 1'b0;
    logic           rst, en, dir, flush, d_valid;
    logic [W-1:0]   d;
    logic [W-1:0]   q_out;
    logic           q_valid;
    logic [W*D-1:0] q_par;
    logic [W-1:0]   master_tap;
    logic [CW-1:0]  fill;
    logic           full, empty;

    ms_shift_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .flush(flush),
        .d(d), .d_valid(d_valid), .q_out(q_out), .q_valid(q_valid),
        .q_par(q_par), .master_tap(master_tap), .fill(fill),
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: what each stage's master and slave hold.
    logic [W-1:0] mm [D];
    logic [W-1:0] ss [D];
    logic         mmv [D];
    logic         ssv [D];
    logic [W-1:0] mq;
    logic         mqv;
    logic [W-1:0] tap_seen;

    typedef struct {
        logic         en;
        logic [W-1:0] d;
        logic         dv;
        logic [W-1:0] e_q;
        logic         e_qv;
        logic [CW-1:0] e_fill;
        logic [W-1:0] e_tap;
    } vec_t;
    vec_t tbl [6];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_pos(input logic r, input logic f, input logic e, input logic dr,
                                      input logic [W-1:0] dd, input logic dv);
        if (r || f) begin
            for (int i = 0; i < D; i++) begin mm[i] = '0; mmv[i] = 1'b0; end
        end else if (e) begin
            // Each word moves one stage in the travel direction; the exit word drops off.
            for (int i = 0; i < D; i++) begin
                int src;
                src = dr ? i + 1 : i - 1;
                if (src < 0 || src >= D) begin mm[i] = dd; mmv[i] = dv; end
                else begin mm[i] = ss[src]; mmv[i] = ssv[src]; end
            end
        end
    endfunction

    function automatic void model_neg(input logic r, input logic dr);
        for (int i = 0; i < D; i++) begin
            ss[i]  = r ? '0 : mm[i];
            ssv[i] = r ? 1'b0 : mmv[i];
        end
        mq  = r ? '0 : (dr ? mm[0] : mm[D-1]);
        mqv = r ? 1'b0 : (dr ? mmv[0] : mmv[D-1]);
    endfunction

    task automatic check_outputs();
        logic [W*D-1:0] ep;
        int             cnt;
        cnt = 0;
        for (int i = 0; i < D; i++) begin
            ep[i*W +: W] = ss[i];
            if (ssv[i]) cnt++;
        end
        chk("q_out", q_out, mq);
        chk("q_valid", q_valid, mqv);
        chk("q_par", q_par, ep);
        chk("fill", fill, cnt);
        chk("full", full, cnt == D);
        chk("empty", empty, cnt == 0);
    endtask

    // One clock: p_* apply at the posedge, n_rst/n_dir are changed before the negedge.
    task automatic cycle(input logic p_rst, input logic p_flush, input logic p_en, input logic p_dir,
                         input logic [W-1:0] p_d, input logic p_dv, input logic n_rst, input logic n_dir);
        rst = p_rst; flush = p_flush; en = p_en; dir = p_dir; d = p_d; d_valid = p_dv;
        @(posedge clk);
        model_pos(p_rst, p_flush, p_en, p_dir, p_d, p_dv);
        #1;
        tap_seen = master_tap;
        chk("master_tap", master_tap, p_dir ? mm[0] : mm[D-1]);
        rst = n_rst; dir = n_dir;
        @(negedge clk);
        model_neg(n_rst, n_dir);
        #1;
        check_outputs();
    endtask

    initial begin
        logic [3:0] qv_seq;
        rst = 1'b1; en = 1'b0; dir = 1'b0; flush = 1'b0; d = '0; d_valid = 1'b0;
        for (int i = 0; i < D; i++) begin mm[i] = '0; ss[i] = '0; mmv[i] = 1'b0; ssv[i] = 1'b0; end
        mq = '0; mqv = 1'b0;

        tbl[0] = '{1'b1, 8'h11, 1'b1, 8'h00, 1'b0, 3'd1, 8'h00};
        tbl[1] = '{1'b1, 8'h22, 1'b1, 8'h00, 1'b0, 3'd2, 8'h00};
        tbl[2] = '{1'b1, 8'h33, 1'b1, 8'h00, 1'b0, 3'd3, 8'h00};
        tbl[3] = '{1'b1, 8'h44, 1'b1, 8'h11, 1'b1, 3'd4, 8'h11};
        tbl[4] = '{1'b0, 8'hFF, 1'b1, 8'h11, 1'b1, 3'd4, 8'h11};
        tbl[5] = '{1'b0, 8'h5A, 1'b0, 8'h11, 1'b1, 3'd4, 8'h11};

        // Reset with data driven on d
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0);
        chk("rst_q_out", q_out, 0);
        chk("rst_q_valid", q_valid, 0);
        chk("rst_fill", fill, 0);
        chk("rst_empty", empty, 1);
        chk("rst_q_par", q_par, 0);

        // Fill / latency / start of hold, table-driven
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 1'b0, tbl[k].en, 1'b0, tbl[k].d, tbl[k].dv, 1'b0, 1'b0);
            chk("tbl_q_out", q_out, tbl[k].e_q);
            chk("tbl_q_valid", q_valid, tbl[k].e_qv);
            chk("tbl_fill", fill, tbl[k].e_fill);
            chk("tbl_tap", tap_seen, tbl[k].e_tap);
        end
        chk("fill_full", full, 1);
        chk("fill_q_par", q_par, 32'h11223344);

        // Hold: en low, d ignored
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom), 1'($urandom), 1'b0, 1'b0);
            chk("hold_q_par", q_par, 32'h11223344);
            chk("hold_fill", fill, 4);
            chk("hold_q_out", q_out, 8'h11);
        end

        // Reverse: dir goes high mid-cycle, then shift toward stage 0
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("rev_q_out_first", q_out, 8'h44);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b1);
        chk("rev_tap", tap_seen, 8'h33);
        chk("rev_q_out_second", q_out, 8'h33);
        chk("rev_stage3", q_par[31:24], 8'hAA);

        // Flush wins over en, then bubbles
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 1'b0);
        chk("flush_fill", fill, 0);
        chk("flush_q_par", q_par, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0);
        chk("bub_fill", fill, 2);
        chk("bub_q_out", q_out, 8'h01);
        qv_seq[0] = q_valid;
        for (int k = 1; k < 4; k++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            qv_seq[k] = q_valid;
        end
        chk("bub_qv_seq", qv_seq, 4'b0101);
        chk("bub_last_q_out", q_out, 8'h04);

        // rst together with flush and en
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'hC1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'hC2, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b1, 1'b0);
        chk("rstflush_fill", fill, 0);
        chk("rstflush_q_par", q_par, 0);
        chk("rstflush_q_valid", q_valid, 0);

        // rst only across a posedge: slaves pick up cleared masters
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'hD1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'hD2, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'hD3, 1'b1, 1'b0, 1'b0);
        chk("short_rst_fill", fill, 0);
        chk("short_rst_q_par", q_par, 0);
        chk("short_rst_empty", empty, 1);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic r_rst, r_fl, r_en, r_dir, n_rst, n_dir;
            r_rst = ($urandom_range(0, 39) == 0);
            r_fl  = ($urandom_range(0, 29) == 0);
            r_en  = ($urandom_range(0, 3) != 0);
            r_dir = (k / 40) % 2 == 1 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
            n_dir = ($urandom_range(0, 9) == 0) ? ~r_dir : r_dir;
            n_rst = ($urandom_range(0, 9) == 0) ? ~r_rst : r_rst;
            cycle(r_rst, r_fl, r_en, r_dir, 8'($urandom), 1'($urandom), n_rst, n_dir);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
